// File: rtl/addsub_op_sequencer_if.sv
// rtl/addsub_op_sequencer_if.sv - request/result handshake bundle for addsub_op_sequencer
interface addsub_op_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_z;
    logic       out_cout;
    logic       out_ovf;
    logic       out_zero;

    modport master (
        output in_valid, in_x, in_y, in_sub, out_ready,
        input  in_ready, out_valid, out_z, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_x, in_y, in_sub, out_ready,
        output in_ready, out_valid, out_z, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_op_sequencer.sv
// rtl/addsub_op_sequencer.sv - handshake front end holding operands to adder_subtractor and registering its result
module addsub_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_op_sequencer_if.slave bus,
    output logic [3:0]           x,
    output logic [3:0]           y,
    output logic                 control,
    input  logic [3:0]           z,
    input  logic                 cout,
    output logic [COUNT_W-1:0]   op_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         x_q, x_d, y_q, y_d;
    logic               control_q, control_d;
    logic [3:0]         out_z_q, out_z_d;
    logic               out_cout_q, out_cout_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_zero_q, out_zero_d;
    logic               out_valid_q, out_valid_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;
    logic               same_sign;
    logic               ovf;

    // in_ready is gated by rst so a request presented during reset is never accepted.
    assign bus.in_ready = (state_q == IDLE) && !rst;

    assign same_sign = (x_q[3] == y_q[3]);
    assign ovf       = (control_q ? !same_sign : same_sign) && (z[3] != x_q[3]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        control_d   = control_q;
        out_z_d     = out_z_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_zero_d  = out_zero_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    x_d       = bus.in_x;
                    y_d       = bus.in_y;
                    control_d = bus.in_sub;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_z_d     = z;
                    out_cout_d  = cout;
                    out_ovf_d   = ovf;
                    out_zero_d  = (z == 4'd0);
                    out_valid_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + COUNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            control_q   <= 1'b0;
            out_z_q     <= 4'd0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            control_q   <= control_d;
            out_z_q     <= out_z_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign control       = control_q;
    assign bus.out_z     = out_z_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_valid = out_valid_q;
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_addsub_op_sequencer.sv
// tb/tb_addsub_op_sequencer.sv - directed bench for addsub_op_sequencer
module tb_addsub_op_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] xa, ya, za, xb, yb, zb;
    logic       ca, cb, cout_a, cout_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       zov_en;
    logic [3:0] zov;
    logic [4:0] sum_a, sum_b;

    int vectors     = 0;
    int miscompares = 0;
    int exp_a       = 0;
    int exp_b       = 0;

    addsub_op_sequencer_if ia();
    addsub_op_sequencer_if ib();

    // Behavioural adder_subtractor: x + (sub ? ~y : y) + sub
    assign sum_a  = {1'b0, xa} + {1'b0, (ca ? ~ya : ya)} + {4'b0, ca};
    assign za     = sum_a[3:0];
    assign cout_a = sum_a[4];
    assign sum_b  = {1'b0, xb} + {1'b0, (cb ? ~yb : yb)} + {4'b0, cb};
    assign zb     = zov_en ? zov : sum_b[3:0];
    assign cout_b = sum_b[4];

    addsub_op_sequencer dut_a (
        .clk(clk), .rst(rst_a), .bus(ia), .x(xa), .y(ya), .control(ca),
        .z(za), .cout(cout_a), .op_count(cnt_a)
    );

    addsub_op_sequencer #(.SETTLE_CYCLES(3), .COUNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib), .x(xb), .y(yb), .control(cb),
        .z(zb), .cout(cout_b), .op_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op_a(input logic [3:0] vx, input logic [3:0] vy, input logic vs,
                        input logic [3:0] ez, input logic ec, input logic eo, input logic ezr);
        ia.in_x = vx; ia.in_y = vy; ia.in_sub = vs; ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        chk("a_x", {4'b0, xa}, {4'b0, vx});
        chk("a_y", {4'b0, ya}, {4'b0, vy});
        chk("a_ctl", {7'b0, ca}, {7'b0, vs});
        chk("a_busy", {7'b0, ia.in_ready}, 8'd0);
        chk("a_early_valid", {7'b0, ia.out_valid}, 8'd0);
        tick();
        chk("a_valid", {7'b0, ia.out_valid}, 8'd1);
        chk("a_z", {4'b0, ia.out_z}, {4'b0, ez});
        chk("a_cout", {7'b0, ia.out_cout}, {7'b0, ec});
        chk("a_ovf", {7'b0, ia.out_ovf}, {7'b0, eo});
        chk("a_zero", {7'b0, ia.out_zero}, {7'b0, ezr});
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        exp_a++;
        chk("a_valid_clr", {7'b0, ia.out_valid}, 8'd0);
        chk("a_ready_back", {7'b0, ia.in_ready}, 8'd1);
        chk("a_count", cnt_a, 8'(exp_a));
    endtask

    task automatic op_b(input logic [3:0] vx, input logic [3:0] vy, input logic vs, input logic [3:0] ez);
        ib.in_x = vx; ib.in_y = vy; ib.in_sub = vs; ib.in_valid = 1'b1;
        tick();
        ib.in_valid = 1'b0;
        tick();
        tick();
        chk("b_not_yet", {7'b0, ib.out_valid}, 8'd0);
        tick();
        chk("b_valid", {7'b0, ib.out_valid}, 8'd1);
        chk("b_z", {4'b0, ib.out_z}, {4'b0, ez});
        ib.out_ready = 1'b1;
        tick();
        ib.out_ready = 1'b0;
        exp_b++;
        chk("b_count", {6'b0, cnt_b}, 8'(exp_b % 4));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; zov_en = 1'b0; zov = 4'd0;
        ia.in_valid = 1'b0; ia.in_x = 4'd0; ia.in_y = 4'd0; ia.in_sub = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_x = 4'd0; ib.in_y = 4'd0; ib.in_sub = 1'b0; ib.out_ready = 1'b0;
        tick();
        ia.in_valid = 1'b1;
        tick();
        chk("rst_in_ready", {7'b0, ia.in_ready}, 8'd0);
        chk("rst_out_valid", {7'b0, ia.out_valid}, 8'd0);
        chk("rst_x", {4'b0, xa}, 8'd0);
        chk("rst_out_z", {4'b0, ia.out_z}, 8'd0);
        chk("rst_count", cnt_a, 8'd0);
        ia.in_valid = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        chk("post_rst_ready", {7'b0, ia.in_ready}, 8'd1);
        chk("post_rst_valid", {7'b0, ia.out_valid}, 8'd0);

        op_a(4'd2,  4'd1,  1'b0, 4'd3,  1'b0, 1'b0, 1'b0);
        op_a(4'd10, 4'd2,  1'b1, 4'd8,  1'b1, 1'b0, 1'b0);
        op_a(4'd4,  4'd10, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0);
        op_a(4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
        op_a(4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1);

        // out_ready while idle must not count anything
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        chk("idle_out_ready_count", cnt_a, 8'd5);
        chk("idle_out_ready_valid", {7'b0, ia.out_valid}, 8'd0);

        // backpressure on 3-1 sub
        ia.in_x = 4'd3; ia.in_y = 4'd1; ia.in_sub = 1'b1; ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            ia.in_valid = (i % 2 == 0); ia.in_x = 4'd5; ia.in_y = 4'd6; ia.in_sub = 1'b0;
            tick();
            chk("bp_z", {4'b0, ia.out_z}, 8'd2);
            chk("bp_cout", {7'b0, ia.out_cout}, 8'd1);
            chk("bp_valid", {7'b0, ia.out_valid}, 8'd1);
            chk("bp_in_ready", {7'b0, ia.in_ready}, 8'd0);
            chk("bp_x_held", {4'b0, xa}, 8'd3);
        end
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        chk("bp_release_ready", {7'b0, ia.in_ready}, 8'd1);
        chk("bp_release_valid", {7'b0, ia.out_valid}, 8'd0);
        chk("bp_count", cnt_a, 8'd6);
        chk("bp_x_kept", {4'b0, xa}, 8'd3);

        // dut_b: reset one cycle into SETTLE abandons the operation
        chk("b_rst_count", {6'b0, cnt_b}, 8'd0);
        ib.in_x = 4'd2; ib.in_y = 4'd1; ib.in_sub = 1'b0; ib.in_valid = 1'b1;
        tick();
        ib.in_valid = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        chk("b_midrst_ready", {7'b0, ib.in_ready}, 8'd0);
        chk("b_midrst_valid", {7'b0, ib.out_valid}, 8'd0);
        chk("b_midrst_x", {4'b0, xb}, 8'd0);
        rst_b = 1'b0;
        tick();
        chk("b_after_rst_ready", {7'b0, ib.in_ready}, 8'd1);
        tick();
        tick();
        tick();
        chk("b_after_rst_valid", {7'b0, ib.out_valid}, 8'd0);
        chk("b_after_rst_count", {6'b0, cnt_b}, 8'd0);

        // dut_b: z changes during settle; the value present at edge N+3 is captured
        zov_en = 1'b1;
        ib.in_x = 4'd2; ib.in_y = 4'd1; ib.in_sub = 1'b0; ib.in_valid = 1'b1;
        tick();
        ib.in_valid = 1'b0;
        zov = 4'd5;
        tick();
        chk("b_settle1_x", {4'b0, xb}, 8'd2);
        chk("b_settle1_valid", {7'b0, ib.out_valid}, 8'd0);
        zov = 4'd6;
        tick();
        chk("b_settle2_x", {4'b0, xb}, 8'd2);
        chk("b_settle2_valid", {7'b0, ib.out_valid}, 8'd0);
        zov = 4'd9;
        tick();
        chk("b_cap_valid", {7'b0, ib.out_valid}, 8'd1);
        chk("b_cap_z", {4'b0, ib.out_z}, 8'd9);
        chk("b_cap_ovf", {7'b0, ib.out_ovf}, 8'd1);
        chk("b_cap_cout", {7'b0, ib.out_cout}, 8'd0);
        chk("b_cap_x", {4'b0, xb}, 8'd2);
        zov_en = 1'b0;
        ib.out_ready = 1'b1;
        tick();
        ib.out_ready = 1'b0;
        exp_b++;
        chk("b_count1", {6'b0, cnt_b}, 8'd1);

        // 2-bit counter wraps: ops 2..5 leave it at 1
        op_b(4'd1, 4'd1, 1'b0, 4'd2);
        op_b(4'd5, 4'd3, 1'b1, 4'd2);
        op_b(4'd0, 4'd1, 1'b1, 4'd15);
        op_b(4'd6, 4'd6, 1'b1, 4'd0);
        chk("b_wrap_count", {6'b0, cnt_b}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
